ifid_skid_reg: RTL and testbench
================================

IFID_SKID_REG -- requirements
Module: ifid_skid_reg

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'hBFC0_0000, the value ifid_pc holds after reset.
REQ-002 SHALL have parameter CNT_W, default 8, the width of the drop counter.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port if_valid  input  1  fetch stage presents an instruction.
REQ-006 SHALL have port if_pc  input  32  PC of the presented instruction.
REQ-007 SHALL have port if_inst  input  32  instruction word.
REQ-008 SHALL have port if_exc  input  1  fetch exception flag (address error).
REQ-009 SHALL have port if_ready  output  1  block accepts a beat this cycle.
REQ-010 SHALL have port id_ready  input  1  decode stage consumes the head beat.
REQ-011 SHALL have port flush  input  1  pipeline flush (branch redirect or exception).
REQ-012 SHALL have port ifid_valid  output  1  head beat valid.
REQ-013 SHALL have port ifid_pc  output  32  head PC.
REQ-014 SHALL have port ifid_inst  output  32  head instruction.
REQ-015 SHALL have port ifid_imm  output  16  ifid_inst[15:0], the feed to the immediate extender.
REQ-016 SHALL have port ifid_rs / ifid_rt  output  5 each  ifid_inst[25:21] / [20:16].
REQ-017 SHALL have port ifid_exc  output  1  head fetch exception flag.
REQ-018 SHALL have port drop_cnt  output  CNT_W  count of valid beats discarded by flush.

Function
REQ-019 SHALL hold two entries: HEAD (drives outputs) and SKID, with state machine EMPTY, ONE (HEAD only), TWO (HEAD+SKID).
REQ-020 SHALL drive if_ready = 1 in EMPTY and ONE, and 0 in TWO; if_ready is a registered function of state only and never depends on id_ready.
REQ-021 SHALL define in_fire = if_valid & if_ready and out_fire = ifid_valid & id_ready.
REQ-022 SHALL drive ifid_valid = 1 exactly in ONE and TWO.
REQ-023 Transitions without flush:
- EMPTY + in_fire -> ONE, beat loaded into HEAD.
- ONE + in_fire & !out_fire -> TWO, beat loaded into SKID.
- ONE + in_fire & out_fire -> ONE, HEAD replaced by the beat.
- ONE + !in_fire & out_fire -> EMPTY.
- TWO + out_fire -> ONE, SKID moved into HEAD.
- All other cases: hold state and payload.
REQ-024 flush SHALL take priority over every other event: next state EMPTY, any same-cycle in_fire beat discarded, and an out_fire in the same cycle is still counted as consumed by decode.
REQ-025 drop_cnt SHALL increment by the number of valid entries discarded by flush (0, 1 or 2), excluding the HEAD if out_fire occurs that cycle and including a discarded in_fire beat, and SHALL saturate at all-ones.
REQ-026 When ifid_valid = 0, ifid_inst SHALL read 32'h0000_0000 (NOP) and ifid_exc SHALL read 0; ifid_pc SHALL keep its last value.
REQ-027 Payload order SHALL be strictly FIFO; no beat is duplicated or lost except by flush.
REQ-028 Latency SHALL be one cycle from in_fire to ifid_valid, and throughput SHALL be one beat per cycle when id_ready is held at 1.

Reset
REQ-029 While rst = 1, SHALL force: state EMPTY, ifid_valid 0, ifid_inst 0, ifid_exc 0, ifid_pc RESET_PC, drop_cnt 0, and if_ready 1 from the first cycle after rst falls.
REQ-030 Reset asserted mid-operation SHALL discard both entries immediately, asynchronously to clk.

Verification
REQ-031 Streaming: id_ready = 1, beats PC 0x100, 0x104, 0x108 on consecutive cycles -> ifid_pc shows 0x100, 0x104, 0x108 one cycle later each; if_ready stays 1.
REQ-032 Stall fill: id_ready = 0, send 0x200 then 0x204 -> state TWO, if_ready = 0, ifid_pc = 0x200; raise id_ready -> 0x200 then 0x204 out, if_ready returns to 1.
REQ-033 Flush in TWO, with id_ready = 0 and if_valid = 1 -> next cycle ifid_valid = 0, ifid_inst = 0, drop_cnt += 2 (the incoming beat is not accepted while if_ready = 0).
REQ-034 Flush in ONE with in_fire and out_fire in the same cycle -> state EMPTY, drop_cnt += 1, decode saw the HEAD beat.
REQ-035 Saturation: CNT_W = 2, issue five single-beat flushes -> drop_cnt stops at 3.
REQ-036 Async reset pulse between clock edges while in TWO -> outputs match REQ-029 before the next edge; ifid_imm = 16'h0000.

Source files
------------

// File: rtl/ifid_skid_reg.sv
// rtl/ifid_skid_reg.sv - IF/ID pipeline register with a two-entry skid buffer and flush-drop counter
module ifid_skid_reg #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter int          CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_valid,
    input  logic [31:0]      if_pc,
    input  logic [31:0]      if_inst,
    input  logic             if_exc,
    output logic             if_ready,
    input  logic             id_ready,
    input  logic             flush,
    output logic             ifid_valid,
    output logic [31:0]      ifid_pc,
    output logic [31:0]      ifid_inst,
    output logic [15:0]      ifid_imm,
    output logic [4:0]       ifid_rs,
    output logic [4:0]       ifid_rt,
    output logic             ifid_exc,
    output logic [CNT_W-1:0] drop_cnt
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic             if_ready_q;
    logic [31:0]      head_pc_q,   head_pc_d;
    logic [31:0]      head_inst_q, head_inst_d;
    logic             head_exc_q,  head_exc_d;
    logic [31:0]      skid_pc_q,   skid_pc_d;
    logic [31:0]      skid_inst_q, skid_inst_d;
    logic             skid_exc_q,  skid_exc_d;
    logic [CNT_W-1:0] drop_cnt_q,  drop_cnt_d;

    logic             in_fire;
    logic             out_fire;
    logic [1:0]       held_cnt;
    logic [1:0]       drop_n;
    logic [CNT_W:0]   drop_sum;

    assign in_fire  = if_valid & if_ready_q;
    assign out_fire = ifid_valid & id_ready;

    // if_ready is registered from the next state so it never sees id_ready combinationally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_EMPTY;
            if_ready_q  <= 1'b1;
            head_pc_q   <= RESET_PC;
            head_inst_q <= 32'h0000_0000;
            head_exc_q  <= 1'b0;
            skid_pc_q   <= 32'h0000_0000;
            skid_inst_q <= 32'h0000_0000;
            skid_exc_q  <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            if_ready_q  <= (state_d != S_TWO);
            head_pc_q   <= head_pc_d;
            head_inst_q <= head_inst_d;
            head_exc_q  <= head_exc_d;
            skid_pc_q   <= skid_pc_d;
            skid_inst_q <= skid_inst_d;
            skid_exc_q  <= skid_exc_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EMPTY: if (in_fire) state_d = S_ONE;
            S_ONE: begin
                if (in_fire && !out_fire)      state_d = S_TWO;
                else if (!in_fire && out_fire) state_d = S_EMPTY;
            end
            S_TWO:   if (out_fire) state_d = S_ONE;
            default: state_d = S_EMPTY;
        endcase
        if (flush) state_d = S_EMPTY;
    end

    always_comb begin
        head_pc_d   = head_pc_q;
        head_inst_d = head_inst_q;
        head_exc_d  = head_exc_q;
        skid_pc_d   = skid_pc_q;
        skid_inst_d = skid_inst_q;
        skid_exc_d  = skid_exc_q;
        if (!flush) begin
            case (state_q)
                S_EMPTY: begin
                    if (in_fire) begin
                        head_pc_d   = if_pc;
                        head_inst_d = if_inst;
                        head_exc_d  = if_exc;
                    end
                end
                S_ONE: begin
                    if (in_fire && out_fire) begin
                        head_pc_d   = if_pc;
                        head_inst_d = if_inst;
                        head_exc_d  = if_exc;
                    end else if (in_fire) begin
                        skid_pc_d   = if_pc;
                        skid_inst_d = if_inst;
                        skid_exc_d  = if_exc;
                    end
                end
                S_TWO: begin
                    if (out_fire) begin
                        head_pc_d   = skid_pc_q;
                        head_inst_d = skid_inst_q;
                        head_exc_d  = skid_exc_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // Beats lost to a flush: held entries, minus a head decode took, plus a beat accepted this cycle
    always_comb begin
        case (state_q)
            S_ONE:   held_cnt = 2'd1;
            S_TWO:   held_cnt = 2'd2;
            default: held_cnt = 2'd0;
        endcase
        drop_n     = held_cnt - {1'b0, out_fire} + {1'b0, in_fire};
        drop_sum   = {1'b0, drop_cnt_q} + (CNT_W+1)'(drop_n);
        drop_cnt_d = drop_cnt_q;
        if (flush) begin
            if (drop_sum[CNT_W]) drop_cnt_d = '1;
            else                 drop_cnt_d = drop_sum[CNT_W-1:0];
        end
    end

    always_comb begin
        ifid_valid = (state_q == S_ONE) || (state_q == S_TWO);
        if_ready   = if_ready_q;
        ifid_pc    = head_pc_q;
        ifid_inst  = ifid_valid ? head_inst_q : 32'h0000_0000;
        ifid_exc   = ifid_valid & head_exc_q;
        ifid_imm   = ifid_inst[15:0];
        ifid_rs    = ifid_inst[25:21];
        ifid_rt    = ifid_inst[20:16];
        drop_cnt   = drop_cnt_q;
    end

endmodule

// File: tb/tb_ifid_skid_reg.sv
// tb/tb_ifid_skid_reg.sv - self-checking bench for ifid_skid_reg against a queue model
module tb_ifid_skid_reg;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        exc;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_exc;
    logic        id_ready;
    logic        flush;

    logic        if_ready_a,   if_ready_b;
    logic        ifid_valid_a, ifid_valid_b;
    logic [31:0] ifid_pc_a,    ifid_pc_b;
    logic [31:0] ifid_inst_a,  ifid_inst_b;
    logic [15:0] ifid_imm_a,   ifid_imm_b;
    logic [4:0]  ifid_rs_a,    ifid_rs_b;
    logic [4:0]  ifid_rt_a,    ifid_rt_b;
    logic        ifid_exc_a,   ifid_exc_b;
    logic [7:0]  drop_a;
    logic [1:0]  drop_b;

    int checks   = 0;
    int failures = 0;

    beat_t       q[$];
    logic [31:0] last_pc;
    int          drops8;
    int          drops2;

    always #5 clk = ~clk;

    ifid_skid_reg #(.RESET_PC(RESET_PC), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
        .if_exc(if_exc), .if_ready(if_ready_a), .id_ready(id_ready), .flush(flush),
        .ifid_valid(ifid_valid_a), .ifid_pc(ifid_pc_a), .ifid_inst(ifid_inst_a),
        .ifid_imm(ifid_imm_a), .ifid_rs(ifid_rs_a), .ifid_rt(ifid_rt_a),
        .ifid_exc(ifid_exc_a), .drop_cnt(drop_a)
    );

    ifid_skid_reg #(.RESET_PC(RESET_PC), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
        .if_exc(if_exc), .if_ready(if_ready_b), .id_ready(id_ready), .flush(flush),
        .ifid_valid(ifid_valid_b), .ifid_pc(ifid_pc_b), .ifid_inst(ifid_inst_b),
        .ifid_imm(ifid_imm_b), .ifid_rs(ifid_rs_b), .ifid_rt(ifid_rt_b),
        .ifid_exc(ifid_exc_b), .drop_cnt(drop_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        last_pc = RESET_PC;
        drops8  = 0;
        drops2  = 0;
    endtask

    task automatic check_all(input string tag);
        logic        ev;
        logic [31:0] epc, einst;
        logic        eexc;
        ev    = (q.size() > 0);
        epc   = ev ? q[0].pc : last_pc;
        einst = ev ? q[0].inst : 32'h0;
        eexc  = ev ? q[0].exc : 1'b0;
        check({tag, ".valid"}, 64'(ifid_valid_a), 64'(ev));
        check({tag, ".pc"},    64'(ifid_pc_a),    64'(epc));
        check({tag, ".inst"},  64'(ifid_inst_a),  64'(einst));
        check({tag, ".exc"},   64'(ifid_exc_a),   64'(eexc));
        check({tag, ".imm"},   64'(ifid_imm_a),   64'(einst[15:0]));
        check({tag, ".rs"},    64'(ifid_rs_a),    64'(einst[25:21]));
        check({tag, ".rt"},    64'(ifid_rt_a),    64'(einst[20:16]));
        check({tag, ".ready"}, 64'(if_ready_a),   64'(q.size() < 2));
        check({tag, ".drop"},  64'(drop_a),       64'(drops8));
        check({tag, ".drop2"}, 64'(drop_b),       64'(drops2));
        check({tag, ".pc2"},   64'(ifid_pc_b),    64'(epc));
    endtask

    // One clock: check current outputs, drive inputs, advance the model across the edge
    task automatic cycle(input string tag, input logic v, input logic [31:0] pc,
                         input logic [31:0] inst, input logic exc,
                         input logic rdy, input logic fl);
        bit    in_f, out_f;
        beat_t b;
        @(negedge clk);
        check_all(tag);
        if_valid = v; if_pc = pc; if_inst = inst; if_exc = exc;
        id_ready = rdy; flush = fl;
        in_f  = v && (q.size() < 2);
        out_f = rdy && (q.size() > 0);
        b.pc = pc; b.inst = inst; b.exc = exc;
        @(posedge clk);
        if (fl) begin
            int n;
            n = q.size() - int'(out_f) + int'(in_f);
            drops8 = (drops8 + n > 255) ? 255 : drops8 + n;
            drops2 = (drops2 + n > 3)   ? 3   : drops2 + n;
            q.delete();
        end else begin
            if (out_f) void'(q.pop_front());
            if (in_f)  q.push_back(b);
        end
        if (q.size() > 0) last_pc = q[0].pc;
    endtask

    initial begin
        rst = 1'b1; if_valid = 0; if_pc = 0; if_inst = 0; if_exc = 0;
        id_ready = 0; flush = 0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all("reset");
        rst = 1'b0;

        // streaming at one beat per cycle
        cycle("stream", 1, 32'h100, 32'h2421_0001, 0, 1, 0);
        cycle("stream", 1, 32'h104, 32'h2442_0002, 1, 1, 0);
        cycle("stream", 1, 32'h108, 32'h2463_0003, 0, 1, 0);
        cycle("stream", 0, 32'h0,   32'h0,         0, 1, 0);
        cycle("stream", 0, 32'h0,   32'h0,         0, 1, 0);

        // stall fill into the skid, then drain in order
        cycle("stall", 1, 32'h200, 32'h8C85_0010, 0, 0, 0);
        cycle("stall", 1, 32'h204, 32'hAC86_0014, 0, 0, 0);
        cycle("stall", 1, 32'h208, 32'h1111_1111, 0, 0, 0);
        cycle("drain", 0, 32'h0,   32'h0,         0, 1, 0);
        cycle("drain", 0, 32'h0,   32'h0,         0, 1, 0);
        cycle("drain", 0, 32'h0,   32'h0,         0, 1, 0);

        // flush while full with an incoming beat that cannot be accepted
        cycle("fl2", 1, 32'h300, 32'h0123_4567, 0, 0, 0);
        cycle("fl2", 1, 32'h304, 32'h89AB_CDEF, 1, 0, 0);
        cycle("fl2", 1, 32'h308, 32'hFFFF_FFFF, 0, 0, 1);
        cycle("fl2", 0, 32'h0,   32'h0,         0, 0, 0);

        // flush in ONE with simultaneous accept and consume
        cycle("fl1", 1, 32'h400, 32'h3C01_ABCD, 0, 0, 0);
        cycle("fl1", 1, 32'h404, 32'h3C02_1234, 0, 1, 1);
        cycle("fl1", 0, 32'h0,   32'h0,         0, 0, 0);

        // narrow counter saturation
        for (int i = 0; i < 5; i++) begin
            cycle("sat", 1, 32'h500 + 32'(i*4), 32'h2000_0000 + 32'(i), 0, 0, 0);
            cycle("sat", 0, 32'h0, 32'h0, 0, 0, 1);
        end
        @(negedge clk);
        check("sat.final", 64'(drop_b), 64'(2'b11));

        // asynchronous reset between edges while full
        cycle("areset", 1, 32'h600, 32'h2484_5555, 1, 0, 0);
        cycle("areset", 1, 32'h604, 32'h24A5_6666, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        check("areset.valid", 64'(ifid_valid_a), 64'(0));
        check("areset.inst",  64'(ifid_inst_a),  64'(0));
        check("areset.exc",   64'(ifid_exc_a),   64'(0));
        check("areset.pc",    64'(ifid_pc_a),    64'(RESET_PC));
        check("areset.drop",  64'(drop_a),       64'(0));
        check("areset.imm",   64'(ifid_imm_a),   64'(16'h0000));
        @(negedge clk);
        rst = 1'b0;
        if_valid = 0; flush = 0; id_ready = 0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check("areset.ready", 64'(if_ready_a), 64'(1));

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            cycle("rand", 1'($urandom_range(0, 3) != 0), $urandom, $urandom,
                  1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 15) == 0));
        end
        @(negedge clk);
        check_all("end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
